// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-fill controller: the fill state
// encoding and the block geometry constants.
package cache_pkg;

  // Fill controller states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // Block geometry: 8 halfword entries form one 16-byte block.
  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_BYTES     = 16;
  localparam int OFFSET_BITS     = 4;
  localparam int WORD_BYTES      = 2;

  // Word counters need one extra bit so they can reach WORDS_PER_BLOCK.
  localparam int CNT_W = $clog2(WORDS_PER_BLOCK) + 1;

endpackage

// File: rtl/cache_word_counter.sv
// Saturating word counter used for both the request and the response side
// of a block fill. It counts enable pulses from 0 up to WORDS_PER_BLOCK and
// then holds, raising o_done.
module cache_word_counter
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_done;

  assign w_done = (r_cnt == CNT_W'(WORDS_PER_BLOCK));

  // Clear has priority over counting; the count holds once a whole block is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_done) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = w_done;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller. On a miss it latches the block base, issues
// one read per cycle for every word of the block, writes each returned word
// into the data array in arrival order and writes the tag together with the
// last word. The pipeline is stalled for the whole fill, including the miss
// cycle itself. Memory latency is never assumed: completion is counted only
// from returned valid pulses.
module cache_fill_fsm #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int WORD_SEL_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_detected,
  input  logic [ADDR_W-1:0]     miss_address,
  input  logic [DATA_W-1:0]     memory_data,
  input  logic                  memory_data_valid,
  output logic                  fsm_busy,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     memory_address,
  output logic                  write_data_array,
  output logic                  write_tag_array,
  output logic [WORD_SEL_W-1:0] word_sel,
  output logic [DATA_W-1:0]     fill_data,
  output logic [ADDR_W-1:0]     fill_block_addr
);

  import cache_pkg::*;

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_FILL = FILL;
  localparam int         STRIDE_SHIFT = $clog2(WORD_BYTES);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_block_base;

  logic              w_in_fill;
  logic              w_start;
  logic              w_issue;
  logic              w_rx;
  logic              w_last;
  logic              w_issue_done;
  logic              w_recv_done;
  logic [CNT_W-1:0]  w_issue_cnt;
  logic [CNT_W-1:0]  w_recv_cnt;
  logic [ADDR_W-1:0] w_word_off;
  logic [ADDR_W-1:0] w_miss_base;

  // A miss is only accepted from IDLE; while reset is held nothing starts,
  // which also keeps the combinational stall low during reset.
  assign w_in_fill = (r_state == ST_FILL);
  assign w_start   = rst_n && (r_state == ST_IDLE) && miss_detected;

  // Requests go out back-to-back until every word of the block was asked for.
  assign w_issue   = w_in_fill && !w_issue_done;

  // Responses are accepted only during a fill; strays in IDLE are dropped.
  assign w_rx      = w_in_fill && memory_data_valid && !w_recv_done;
  assign w_last    = w_rx && (w_recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

  // Block base: offset bits of the missing byte address cleared so the fill
  // always starts at word 0 of the block.
  assign w_miss_base = {miss_address[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  // Byte offset of the current request inside the block.
  assign w_word_off  = ADDR_W'(w_issue_cnt) << STRIDE_SHIFT;

  cache_word_counter u_issue_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start),
    .i_en   (w_issue),
    .o_cnt  (w_issue_cnt),
    .o_done (w_issue_done)
  );

  cache_word_counter u_recv_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start),
    .i_en   (w_rx),
    .o_cnt  (w_recv_cnt),
    .o_done (w_recv_done)
  );

  // Fill state: enter on an accepted miss, leave right after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (w_start) begin
      r_state <= ST_FILL;
    end else if (w_last) begin
      r_state <= ST_IDLE;
    end
  end

  // Latch the block base once per fill; misses during a fill do not re-latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_block_base <= '0;
    end else if (w_start) begin
      r_block_base <= w_miss_base;
    end
  end

  assign fsm_busy         = w_in_fill || w_start;
  assign mem_en           = w_issue;
  assign memory_address   = w_issue ? (r_block_base + w_word_off) : '0;
  assign write_data_array = w_rx;
  assign write_tag_array  = w_last;
  assign word_sel         = w_rx ? w_recv_cnt[WORD_SEL_W-1:0] : '0;
  assign fill_data        = rst_n ? memory_data : '0;
  assign fill_block_addr  = r_block_base;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a vector table for reset/idle and the reference
// 4-cycle-latency fill, then model-checked sequences for irregular latency,
// misses during a fill, top-of-memory, mid-fill reset and random fills.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic [15:0] memory_data = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy;
  logic        mem_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  word_sel;
  logic [15:0] fill_data;
  logic [15:0] fill_block_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_fill_fsm #(
    .ADDR_W          (16),
    .DATA_W          (16),
    .WORDS_PER_BLOCK (8),
    .WORD_SEL_W      (3)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .word_sel          (word_sel),
    .fill_data         (fill_data),
    .fill_block_addr   (fill_block_addr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst_n;
    logic        miss;
    logic [15:0] ma;
    logic        vld;
    logic [15:0] md;
    logic        e_busy;
    logic        e_en;
    logic [15:0] e_addr;
    logic        e_wr;
    logic [2:0]  e_ws;
    logic        e_tag;
    logic [15:0] e_blk;
  } vec_t;

  vec_t vt[$];

  // ---------------- reference model ----------------
  // A fill is described by its start: requests k=1..8 cycles into the fill
  // go to base+2*(k-1); the n-th valid during the fill writes word n and the
  // 8th one also writes the tag and ends the fill.
  bit          m_fill;
  logic [15:0] m_base;
  logic [15:0] m_blk;
  int          m_k;
  int          m_rx;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rsp_t;

  rsp_t mq[$];
  int   cyc = 0;
  int   last_due = 0;
  int   lat_mode = 0;

  task automatic model_reset();
    m_fill = 1'b0;
    m_base = '0;
    m_blk  = '0;
    m_k    = 0;
    m_rx   = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (!m_fill) begin
      if (miss_detected) begin
        m_fill = 1'b1;
        m_base = miss_address & 16'hFFF0;
        m_blk  = m_base;
        m_k    = 1;
        m_rx   = 0;
      end
    end else begin
      m_k++;
      if (memory_data_valid) begin
        m_rx++;
        if (m_rx == 8) m_fill = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string nm);
    logic        e_busy, e_en, e_wr, e_tag;
    logic [15:0] e_addr;
    e_busy = rst_n && (m_fill || miss_detected);
    e_en   = rst_n && m_fill && (m_k <= 8);
    e_addr = e_en ? 16'(m_base + 16'(2 * (m_k - 1))) : 16'h0000;
    e_wr   = rst_n && m_fill && memory_data_valid;
    e_tag  = e_wr && (m_rx == 7);
    chk({nm, ".busy"}, fsm_busy, e_busy);
    chk({nm, ".mem_en"}, mem_en, e_en);
    chk({nm, ".addr"}, memory_address, e_addr);
    chk({nm, ".wr"}, write_data_array, e_wr);
    chk({nm, ".tag"}, write_tag_array, e_tag);
    chk({nm, ".blk"}, fill_block_addr, m_blk);
    if (e_wr) begin
      chk({nm, ".word_sel"}, word_sel, 32'(m_rx));
      chk({nm, ".fill_data"}, fill_data, memory_data);
    end
    if (!rst_n) chk({nm, ".fill_data_rst"}, fill_data, 32'h0);
  endtask

  // One clock cycle: drive inputs, let memory respond from its queue,
  // compare against the model, log new requests, then advance the model.
  task automatic step(input logic miss, input logic [15:0] ma, input string nm);
    rsp_t r;
    int   d;
    @(negedge clk);
    miss_detected = miss;
    miss_address  = ma;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      r = mq.pop_front();
      memory_data_valid = 1'b1;
      memory_data       = r.data;
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'($urandom);
    end
    #1;
    check_outputs(nm);
    if (m_fill && m_k <= 8) begin
      if (lat_mode == 0) begin
        r.due  = cyc + 4;
        r.data = 16'hA000 + 16'(m_k - 1);
      end else begin
        d = last_due + 1 + int'($urandom_range(0, 3));
        if (d < cyc + 1) d = cyc + 1;
        last_due = d;
        r.due  = d;
        r.data = 16'($urandom);
      end
      mq.push_back(r);
    end
    @(posedge clk);
    model_edge();
    cyc++;
  endtask

  task automatic run_until_idle(input logic miss, input logic [15:0] ma, input string nm);
    int n = 0;
    while (m_fill && n < 200) begin
      step(miss, ma, nm);
      n++;
    end
    if (m_fill) fail_now({nm, ".timeout"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   n;
    logic rnd_miss;

    // Reset and idle vectors: stray valids and a miss under reset do nothing.
    v = '{1'b0, 1'b1, 16'h1236, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 16'h0};
    vt.push_back(v);
    v = '{1'b1, 1'b0, 16'h1236, 1'b1, 16'h2222, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 16'h0};
    vt.push_back(v);
    vt.push_back(v);
    v = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 16'h0};
    vt.push_back(v);
    // Reference fill: miss at 0x1236 in cycle 0, 4-cycle memory.
    for (int c = 0; c <= 13; c++) begin
      v.rst_n  = 1'b1;
      v.miss   = (c == 0);
      v.ma     = 16'h1236;
      v.vld    = (c >= 5 && c <= 12);
      v.md     = v.vld ? 16'hA000 + 16'(c - 5) : 16'h5555;
      v.e_busy = (c <= 12);
      v.e_en   = (c >= 1 && c <= 8);
      v.e_addr = v.e_en ? 16'h1230 + 16'(2 * (c - 1)) : 16'h0000;
      v.e_wr   = v.vld;
      v.e_ws   = 3'(c - 5);
      v.e_tag  = (c == 12);
      v.e_blk  = (c >= 1) ? 16'h1230 : 16'h0000;
      vt.push_back(v);
    end

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      rst_n             = vt[i].rst_n;
      miss_detected     = vt[i].miss;
      miss_address      = vt[i].ma;
      memory_data_valid = vt[i].vld;
      memory_data       = vt[i].md;
      #1;
      chk($sformatf("vec%0d.busy", i), fsm_busy, vt[i].e_busy);
      chk($sformatf("vec%0d.mem_en", i), mem_en, vt[i].e_en);
      chk($sformatf("vec%0d.addr", i), memory_address, vt[i].e_addr);
      chk($sformatf("vec%0d.wr", i), write_data_array, vt[i].e_wr);
      chk($sformatf("vec%0d.tag", i), write_tag_array, vt[i].e_tag);
      chk($sformatf("vec%0d.blk", i), fill_block_addr, vt[i].e_blk);
      if (vt[i].e_wr) begin
        chk($sformatf("vec%0d.word_sel", i), word_sel, vt[i].e_ws);
        chk($sformatf("vec%0d.fill_data", i), fill_data, vt[i].md);
      end
      if (!vt[i].rst_n) chk($sformatf("vec%0d.fill_data_rst", i), fill_data, 32'h0);
    end

    // Re-synchronise DUT and model with a reset.
    @(negedge clk);
    miss_detected = 1'b0;
    memory_data_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_sync");
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();

    // Irregular latency: valid gaps of 0-3 cycles.
    lat_mode = 1;
    last_due = cyc;
    step(1'b1, 16'h1236, "irr");
    run_until_idle(1'b0, 16'h0000, "irr");
    step(1'b0, 16'h0000, "irr_post");

    // Miss held high, address moved to 0x4000 during the fill.
    lat_mode = 0;
    step(1'b1, 16'h1236, "hold");
    for (int i = 0; i < 4; i++) step(1'b1, 16'h1236, "hold");
    run_until_idle(1'b1, 16'h4000, "hold");
    step(1'b1, 16'h4000, "hold_restart");
    chk("hold.new_fill", m_fill, 1'b1);
    run_until_idle(1'b0, 16'h0000, "hold2");
    chk("hold2.blk", fill_block_addr, 32'h4000);

    // Top-of-memory block.
    step(1'b1, 16'hFFFC, "top");
    run_until_idle(1'b0, 16'h0000, "top");
    chk("top.blk", fill_block_addr, 32'hFFF0);

    // Reset after the third data write.
    step(1'b1, 16'h2468, "rstmid");
    n = 0;
    while (m_rx < 3 && n < 40) begin
      step(1'b0, 16'h0000, "rstmid");
      n++;
    end
    if (m_rx < 3) fail_now("rstmid.wait");
    @(negedge clk);
    miss_detected     = 1'b1;
    memory_data_valid = 1'b1;
    memory_data       = 16'hBEEF;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rstmid_async");
    @(posedge clk);
    #1;
    check_outputs("rstmid_hold");
    @(negedge clk);
    miss_detected     = 1'b0;
    memory_data_valid = 1'b0;
    rst_n = 1'b1;
    n = 0;
    while (mq.size() > 0 && n < 40) begin
      step(1'b0, 16'h0000, "stray");
      n++;
    end
    if (mq.size() > 0) fail_now("stray.drain");
    step(1'b0, 16'h0000, "stray_post");

    // Random fills with random misses during the fill.
    for (int f = 0; f < 30; f++) begin
      lat_mode = int'($urandom_range(0, 1));
      last_due = cyc;
      n = int'($urandom_range(0, 3));
      for (int g = 0; g < n; g++) step(1'b0, 16'($urandom), "rnd_idle");
      step(1'b1, 16'($urandom), "rnd_start");
      n = 0;
      while (m_fill && n < 200) begin
        rnd_miss = ($urandom_range(0, 3) == 0);
        step(rnd_miss, 16'($urandom), "rnd");
        n++;
      end
      if (m_fill) fail_now("rnd.timeout");
    end
    step(1'b0, 16'h0000, "final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
